mnist_capture: RTL

Camera-side front end for the 32x32 binary MNIST frame buffer. Consumes the grayscale camera pixel stream and crops a square region of interest (ROI). Box-averages ROI cells of SCALE x SCALE pixels, thresholds each cell to 1 bit, and drives the 1024 x 1-bit frame-buffer write port. Armed per capture by the controller; signals completion so the classifier can start reading.

---
 rtl/mnist_capture.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/mnist_capture.sv
// mnist_capture: crops a square ROI from a grayscale camera stream, box-averages
// cells into a thresholded 32x32 bitmap. Optional feature macro: MNIST_CAP_AUTOTHRESH_EN.
module mnist_capture #(
  parameter int X0         = 192,
  parameter int Y0         = 112,
  parameter int SCALE_LOG2 = 3,
  parameter int THRESH     = 128
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic       vsync_i,
  input  logic       href_i,
  input  logic       pix_valid_i,
  input  logic [7:0] pix_gray_i,
  output logic [9:0] wr_addr_o,
  output logic       wr_data_o,
  output logic       wr_en_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       frame_err_o
);

  localparam int S     = SCALE_LOG2;
  localparam int ROI   = 32 << S;
  localparam int ACC_W = 8 + 2 * S;
  localparam int REL_W = S + 5;

  localparam logic [11:0] X_LO = 12'(X0);
  localparam logic [11:0] X_HI = 12'(X0 + ROI);
  localparam logic [11:0] Y_LO = 12'(Y0);
  localparam logic [11:0] Y_HI = 12'(Y0 + ROI);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_FRAME,
    CAPTURE
  } state_e;

  state_e state_q, state_d;

  logic             vsyncPrev_q;
  logic             hrefPrev_q;
  logic [11:0]      col_q, col_d;
  logic [11:0]      row_q, row_d;
  logic [10:0]      cellCnt_q, cellCnt_d;
  logic [ACC_W-1:0] acc_q [32];

  logic             wrEn_q, wrEn_d;
  logic             lastWr_q, lastWr_d;
  logic [9:0]       wrAddr_q, wrAddr_d;
  logic             wrData_q, wrData_d;
  logic             done_q, done_d;
  logic             frameErr_q, frameErr_d;

  logic             vsyncRise;
  logic             hrefFall;
  logic             pixFire;
  logic             roiHit;
  logic             cellLoad;
  logic             cellDone;
  logic             captureEnd;
  logic             abortFrame;
  logic [REL_W-1:0] relX, relY;
  logic [4:0]       cellX, cellY;
  logic [S-1:0]     subX, subY;
  logic [ACC_W-1:0] cellSum;
  logic [7:0]       cellAvg;
  logic [7:0]       activeThresh;
  logic [10:0]      cellCntInc;

  assign vsyncRise = vsync_i & ~vsyncPrev_q;
  assign hrefFall  = ~href_i & hrefPrev_q;
  assign pixFire   = pix_valid_i & href_i;

  assign roiHit = pixFire && (state_q == CAPTURE) &&
                  (col_q >= X_LO) && (col_q < X_HI) &&
                  (row_q >= Y_LO) && (row_q < Y_HI);

  // Offsets inside the ROI; only meaningful when roiHit is set.
  assign relX  = REL_W'(col_q - X_LO);
  assign relY  = REL_W'(row_q - Y_LO);
  assign cellX = 5'(relX >> S);
  assign cellY = 5'(relY >> S);
  assign subX  = relX[S-1:0];
  assign subY  = relY[S-1:0];

  assign cellLoad = roiHit && (subX == '0) && (subY == '0);
  assign cellDone = roiHit && (&subX) && (&subY);
  assign cellSum  = acc_q[cellX] + ACC_W'(pix_gray_i);
  assign cellAvg  = 8'(cellSum >> (2 * S));

  assign cellCntInc = cellCnt_q + 11'(cellDone);
  assign captureEnd = wrEn_q && lastWr_q;
  // A coincident final completion is not an abort: that frame is already whole.
  assign abortFrame = vsyncRise && (state_q == CAPTURE) && (cellCntInc != 11'd1024);

`ifdef MNIST_CAP_AUTOTHRESH_EN
  localparam int SUM_W = 24 + 2 * S;

  logic [SUM_W-1:0] sum_q, sum_d;
  logic [7:0]       thresh_q, thresh_d;

  always_comb begin
    sum_d    = sum_q;
    thresh_d = thresh_q;
    if (roiHit) begin
      sum_d = sum_q + SUM_W'(pix_gray_i);
    end
    if (vsyncRise) begin
      sum_d = '0;
    end
    if (captureEnd) begin
      thresh_d = 8'(sum_q >> (10 + 2 * S));
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sum_q    <= '0;
      thresh_q <= 8'(THRESH);
    end else begin
      sum_q    <= sum_d;
      thresh_q <= thresh_d;
    end
  end

  assign activeThresh = thresh_q;
`else
  assign activeThresh = 8'(THRESH);
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:       if (start_i)    state_d = WAIT_FRAME;
      WAIT_FRAME: if (vsyncRise)  state_d = CAPTURE;
      CAPTURE:    if (captureEnd) state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end

  // vsync clearing is applied last so a coincident cell completion still writes.
  always_comb begin
    col_d     = col_q;
    row_d     = row_q;
    cellCnt_d = cellCnt_q;
    if (pixFire && (col_q != '1)) begin
      col_d = col_q + 12'd1;
    end
    if (hrefFall) begin
      col_d = '0;
      if (row_q != '1) begin
        row_d = row_q + 12'd1;
      end
    end
    if (cellDone) begin
      cellCnt_d = cellCntInc;
    end
    if (vsyncRise) begin
      col_d     = '0;
      row_d     = '0;
      cellCnt_d = '0;
    end
  end

  always_comb begin
    wrEn_d     = cellDone;
    lastWr_d   = cellDone && (cellCnt_q == 11'd1023);
    wrAddr_d   = wrAddr_q;
    wrData_d   = wrData_q;
    done_d     = captureEnd;
    frameErr_d = abortFrame;
    if (cellDone) begin
      wrAddr_d = {cellY, cellX};
      wrData_d = (cellAvg < activeThresh);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      vsyncPrev_q <= 1'b0;
      hrefPrev_q  <= 1'b0;
      col_q       <= '0;
      row_q       <= '0;
      cellCnt_q   <= '0;
      wrEn_q      <= 1'b0;
      lastWr_q    <= 1'b0;
      wrAddr_q    <= '0;
      wrData_q    <= 1'b0;
      done_q      <= 1'b0;
      frameErr_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      vsyncPrev_q <= vsync_i;
      hrefPrev_q  <= href_i;
      col_q       <= col_d;
      row_q       <= row_d;
      cellCnt_q   <= cellCnt_d;
      wrEn_q      <= wrEn_d;
      lastWr_q    <= lastWr_d;
      wrAddr_q    <= wrAddr_d;
      wrData_q    <= wrData_d;
      done_q      <= done_d;
      frameErr_q  <= frameErr_d;
    end
  end

  // One running sum per cell column; a cell row reuses them once per band.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 32; i++) begin
        acc_q[i] <= '0;
      end
    end else if (roiHit) begin
      acc_q[cellX] <= cellLoad ? ACC_W'(pix_gray_i) : cellSum;
    end
  end

  assign wr_addr_o   = wrAddr_q;
  assign wr_data_o   = wrData_q;
  assign wr_en_o     = wrEn_q;
  assign busy_o      = (state_q != IDLE);
  assign done_o      = done_q;
  assign frame_err_o = frameErr_q;

endmodule
